// File: rtl/pipe_stage_buffer.sv
// Pipeline-stage register with valid/ready handshake, flush and a saturating flush-drop counter.
// Define PIPE_BUF_SKID_EN for the two-entry skid store with a registered in_ready.
module pipe_stage_buffer #(
  parameter int DATA_W = 80,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              in_fire, out_fire;
  logic [1:0]        drop_inc;
  logic [CNT_W:0]    drop_sum;

`ifdef PIPE_BUF_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;

  // in_ready decodes only the state register, so out_ready never reaches it.
  assign in_ready  = (state_q != ST_FULL);
  assign occupancy = {state_q == ST_FULL, state_q == ST_ONE};
`else
  assign in_ready  = (state_q == ST_EMPTY) || out_ready;
  assign occupancy = {1'b0, state_q == ST_ONE};
`endif

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign drop_cnt  = drop_cnt_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_BUF_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
`ifdef PIPE_BUF_SKID_EN
      skid_d  = '0;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
`ifdef PIPE_BUF_SKID_EN
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = ST_FULL;
`endif
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
`ifdef PIPE_BUF_SKID_EN
        ST_FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Entries lost to a flush: everything held minus what leaves this cycle, plus what enters.
  always_comb begin
    drop_inc   = occupancy - {1'b0, out_fire} + {1'b0, in_fire};
    drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(drop_inc);
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  // NOTE: payload registers are reset too, because out_data must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef PIPE_BUF_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= '0;
    end else begin
      skid_q <= skid_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Self-checking bench for pipe_stage_buffer: vector table, queue scoreboard, corner-case sequences.
// Works with or without PIPE_BUF_SKID_EN; expectations follow the selected build.
module tb_pipe_stage_buffer;
  localparam int DATA_W = 80;
  localparam int CNT_W  = 16;
  localparam int MAXC   = (1 << CNT_W) - 1;
`ifdef PIPE_BUF_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              clk, rst_n;
  logic              in_valid, in_ready, flush, out_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  drop_cnt;

  logic       s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
  logic [7:0] s_in_data, s_out_data;
  logic [1:0] s_occupancy, s_drop_cnt;

  pipe_stage_buffer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  pipe_stage_buffer #(.DATA_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .flush(s_flush), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .drop_cnt(s_drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic              iv;
    logic [DATA_W-1:0] id;
    logic              ordy;
    logic              fl;
    logic              e_valid;
    logic [DATA_W-1:0] e_data;
    logic [1:0]        e_occ;
  } vec_t;

  vec_t              vecs[$];
  logic [DATA_W-1:0] sb[$];
  logic [DATA_W-1:0] m_last;
  int                m_drop;
  int                n_vec, n_fail;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready(input logic ordy);
    if (SKID) return sb.size() < 2;
    return (sb.size() == 0) || ordy;
  endfunction

  task automatic check_model();
    logic [DATA_W-1:0] e_data;
    e_data = (sb.size() != 0) ? sb[0] : m_last;
    check("sb.out_valid", 128'(out_valid), 128'(sb.size() != 0));
    check("sb.out_data",  128'(out_data),  128'(e_data));
    check("sb.occupancy", 128'(occupancy), 128'(sb.size()));
    check("sb.in_ready",  128'(in_ready),  128'(model_ready(out_ready)));
    check("sb.drop_cnt",  128'(drop_cnt),  128'(m_drop));
  endtask

  // Drive one cycle at posedge+1, check against the scoreboard, clock, then advance the model.
  task automatic apply(input logic iv, input logic [DATA_W-1:0] id, input logic ordy, input logic fl);
    logic ifire, ofire;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_model();
    ifire = iv && model_ready(ordy);
    ofire = (sb.size() != 0) && ordy;
    @(posedge clk);
    #1;
    if (fl) begin
      m_drop = m_drop + sb.size() - int'(ofire) + int'(ifire);
      if (m_drop > MAXC) m_drop = MAXC;
      sb.delete();
      m_last = '0;
    end else begin
      if (ofire) m_last = sb.pop_front();
      if (ifire) sb.push_back(id);
    end
  endtask

  initial begin
    int d0;
    logic [95:0] r;

    n_vec = 0; n_fail = 0; m_last = '0; m_drop = 0;
    sb.delete();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0; s_flush = 1'b0;

    // Reset values, visible before any clock edge.
    #2;
    check("rst.out_valid", 128'(out_valid), 128'(0));
    check("rst.out_data",  128'(out_data),  128'(0));
    check("rst.occupancy", 128'(occupancy), 128'(0));
    check("rst.drop_cnt",  128'(drop_cnt),  128'(0));
    check("rst.in_ready",  128'(in_ready),  128'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Stream 1..8, drain, then flush in ONE with both fires in the flush cycle.
    for (int k = 1; k <= 8; k++)
      vecs.push_back('{1'b1, DATA_W'(k), 1'b1, 1'b0, 1'b1, DATA_W'(k), 2'd1});
    vecs.push_back('{1'b0, DATA_W'(0), 1'b1, 1'b0, 1'b0, DATA_W'(8), 2'd0});
    vecs.push_back('{1'b1, DATA_W'('h55), 1'b0, 1'b0, 1'b1, DATA_W'('h55), 2'd1});
    vecs.push_back('{1'b1, DATA_W'('h66), 1'b1, 1'b1, 1'b0, DATA_W'(0), 2'd0});
    foreach (vecs[i]) begin
      apply(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl);
      check($sformatf("vec%0d.out_valid", i), 128'(out_valid), 128'(vecs[i].e_valid));
      check($sformatf("vec%0d.out_data", i),  128'(out_data),  128'(vecs[i].e_data));
      check($sformatf("vec%0d.occupancy", i), 128'(occupancy), 128'(vecs[i].e_occ));
    end
    check("vec.drop_after_one_flush", 128'(drop_cnt), 128'(1));

    // Skid fill with downstream stalled, then drain.
    apply(1'b1, DATA_W'('hA), 1'b0, 1'b0);
    apply(1'b1, DATA_W'('hB), 1'b0, 1'b0);
    check("fill.occupancy", 128'(occupancy), 128'(SKID ? 2 : 1));
    check("fill.in_ready",  128'(in_ready),  128'(0));
    check("fill.out_data",  128'(out_data),  128'('hA));
    apply(1'b0, DATA_W'(0), 1'b1, 1'b0);
    check("drain1.out_valid", 128'(out_valid), 128'(SKID));
    check("drain1.out_data",  128'(out_data),  128'(SKID ? 'hB : 'hA));
    apply(1'b0, DATA_W'(0), 1'b1, 1'b0);
    check("drain2.out_valid", 128'(out_valid), 128'(0));
    check("drain2.out_data",  128'(out_data),  128'(SKID ? 'hB : 'hA));

    // Flush while full (input presented but refused).
    apply(1'b1, DATA_W'('hC), 1'b0, 1'b0);
    apply(1'b1, DATA_W'('hD), 1'b0, 1'b0);
    d0 = m_drop;
    apply(1'b1, DATA_W'('hE), 1'b0, 1'b1);
    check("flfull.out_valid", 128'(out_valid), 128'(0));
    check("flfull.out_data",  128'(out_data),  128'(0));
    check("flfull.occupancy", 128'(occupancy), 128'(0));
    check("flfull.drop_cnt",  128'(drop_cnt),  128'(d0 + (SKID ? 2 : 1)));

    // Flush in ONE with output fire and input fire together.
    apply(1'b1, DATA_W'('h11), 1'b0, 1'b0);
    d0 = m_drop;
    apply(1'b1, DATA_W'('h22), 1'b1, 1'b1);
    check("flone.out_valid", 128'(out_valid), 128'(0));
    check("flone.occupancy", 128'(occupancy), 128'(0));
    check("flone.drop_cnt",  128'(drop_cnt),  128'(d0 + 1));

    // Random traffic against the scoreboard.
    for (int c = 0; c < 80; c++) begin
      r = {$urandom(), $urandom(), $urandom()};
      apply($urandom_range(0, 3) != 0, r[DATA_W-1:0], $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) == 0);
    end
    apply(1'b0, DATA_W'(0), 1'b1, 1'b0);
    apply(1'b0, DATA_W'(0), 1'b1, 1'b0);
    apply(1'b0, DATA_W'(0), 1'b1, 1'b0);

    // Asynchronous reset mid-stream, then reset held together with flush.
    apply(1'b1, DATA_W'('h77), 1'b1, 1'b0);
    apply(1'b1, DATA_W'('h78), 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", 128'(out_valid), 128'(0));
    check("arst.out_data",  128'(out_data),  128'(0));
    check("arst.occupancy", 128'(occupancy), 128'(0));
    check("arst.drop_cnt",  128'(drop_cnt),  128'(0));
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("arst_flush.drop_cnt",  128'(drop_cnt),  128'(0));
    check("arst_flush.out_valid", 128'(out_valid), 128'(0));
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    sb.delete(); m_last = '0; m_drop = 0;
    apply(1'b1, DATA_W'('h99), 1'b1, 1'b0);
    apply(1'b0, DATA_W'(0), 1'b1, 1'b0);
    check("post_rst.out_data", 128'(out_data), 128'('h99));

    // Saturation on the 2-bit counter: five flushes of one held entry each.
    for (int k = 1; k <= 5; k++) begin
      s_in_valid = 1'b1; s_in_data = 8'(k); s_out_ready = 1'b0; s_flush = 1'b0;
      @(posedge clk);
      #1;
      s_in_valid = 1'b0; s_flush = 1'b1;
      @(posedge clk);
      #1;
      s_flush = 1'b0;
      check($sformatf("sat%0d.drop_cnt", k), 128'(s_drop_cnt), 128'(k > 3 ? 3 : k));
      check($sformatf("sat%0d.occupancy", k), 128'(s_occupancy), 128'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buffer.md
# pipe_stage_buffer

Parametrised pipeline-stage register that generalises the fetch/decode inter-stage buffer to any payload width. Adds a valid/ready handshake with back-pressure, a synchronous flush that discards in-flight entries, an optional two-entry skid store, and a saturating count of entries killed by flush. Instantiated between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) with the stage's fields packed into one payload bus.

## Interface
- `DATA_W`, default 80: payload width (16-bit instruction + 32-bit PC + 32-bit next PC for IF/ID).
- `CNT_W`, default 16: width of the flush-drop counter.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream stage presents a payload.
- `in_ready` out 1: buffer accepts the payload this cycle.
- `in_data` in DATA_W: upstream payload.
- `flush` in 1: synchronous kill of all held and incoming entries, level-sensitive.
- `out_valid` out 1: `out_data` holds a live entry.
- `out_ready` in 1: downstream consumes the entry this cycle.
- `out_data` out DATA_W: payload to the downstream stage.
- `occupancy` out 2: number of live entries (0..2).
- `drop_cnt` out CNT_W: saturating count of entries discarded by flush.

## Operation
- An input fire is `in_valid && in_ready`. An output fire is `out_valid && out_ready`.
- States (with skid): EMPTY (occ 0), ONE (main valid), FULL (main and skid valid).
- EMPTY:
  - Input fire: load main, go to ONE.
- ONE:
  - Input fire and output fire: load main from `in_data`, stay in ONE.
  - Input fire only: load skid, go to FULL.
  - Output fire only: go to EMPTY.
- FULL:
  - `in_ready` is 0.
  - Output fire: main <= skid, go to ONE.
- Flush has priority over everything:
  - Next state is EMPTY and `out_valid` is 0.
  - main and skid payloads are cleared to all-zero.
  - An input presented in the flush cycle is not stored.
- `drop_cnt` increments on a flush cycle by (occupancy − (1 if output fires that cycle else 0)) + (1 if `in_valid && in_ready`).
  - It saturates at 2^CNT_W−1 and never wraps.
- In EMPTY without flush, `out_data` holds the last value.
- Payload is never modified in transit. Order is strictly FIFO.

## Timing
- Reset values, asynchronous while `rst_n` is 0: `out_valid`=0, `out_data`=0, skid=0, `occupancy`=0, `drop_cnt`=0.
  - With skid: `in_ready`=1 after reset.
- Latency: an input accepted at edge N appears on `out_data` with `out_valid`=1 after edge N (one cycle).
- Throughput: one entry per cycle while `out_ready`=1.
- With skid, `in_ready` is registered: `in_ready` = !(state==FULL). There is no combinational path from `out_ready` to `in_ready`.
- `out_valid`, once asserted, stays high with stable `out_data` until an output fire or a flush.
- Reset asserted mid-transfer: all entries are lost immediately, with no drop counting.
- Flush and reset asserted together: reset wins.

## Configuration
- `PIPE_BUF_SKID_EN` defined: two-entry skid behaviour as above. `occupancy` spans 0..2 and `in_ready` is registered.
- `PIPE_BUF_SKID_EN` undefined: single register with no FULL state.
  - `in_ready` = `!out_valid || out_ready`, combinational.
  - `occupancy` is 0..1 with bit 1 tied to 0.
  - Flush and drop rules are unchanged.

## Test plan
- Reset, then stream `in_data`=1..8 with `in_valid`=1 and `out_ready`=1 → outputs 1..8 on consecutive cycles, each one cycle after its input; `occupancy` stays 1.
- Skid fill (skid on): push 0xA then 0xB with `out_ready`=0 → `occupancy`=2, `in_ready`=0, `out_data`=0xA. Raise `out_ready` → 0xA, then 0xB, then EMPTY.
- Flush in FULL with `in_valid`=1 and `out_ready`=0 → next cycle `out_valid`=0, `out_data`=0, `occupancy`=0, `drop_cnt`=+2 (the input is refused because `in_ready`=0).
- Flush in ONE with an output fire and an input fire in the same cycle → `drop_cnt`=+1 and the buffer goes to EMPTY.
- Saturation: with `CNT_W`=2, issue 5 flushes each with occ=1 → `drop_cnt` stops at 3.
- Assert `rst_n`=0 asynchronously mid-stream (between edges) → all outputs go to reset values immediately without waiting for `clk`; `drop_cnt` stays 0.
